vector_stream_alu: RTL and testbench
====================================

Name: vector_stream_alu

Overview:
- Multi-cycle, lane-parallel successor to the single-shot element ALU.
- Takes two operand vectors of up to MAX_LEN elements, or one vector plus a broadcast scalar, and processes LANES elements per clock under a small FSM.
- Adds optional signed saturation, a running sum reduction of the result vector, and a start/busy/done handshake so the bus/HAL side can queue work.
- Sits between the operand register file and the result register file in the accelerator datapath.

Parameters:
- BITS, 8, element width (signed two's complement).
- LANES, 4, elements processed per RUN cycle; must be 1 or more and divide MAX_LEN.
- MAX_LEN, 16, maximum vector length and depth of the A/B/S arrays.
- MULT_SHIFT, 0, arithmetic right shift applied to the full-width product before truncation or saturation.
- LEN_W, 8, width of the length fields.
- RW, BITS+$clog2(MAX_LEN), width of the reduction result.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a new operation; sampled only in IDLE.
- A  in  BITS x MAX_LEN  operand vector A (unpacked array).
- A_len  in  LEN_W  valid elements in A.
- B  in  BITS x MAX_LEN  operand vector B.
- B_len  in  LEN_W  valid elements in B.
- scalar  in  BITS  broadcast operand.
- scalar_sel  in  1  1 = use scalar in place of B.
- op_sel  in  3  0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 XOR, 6 MIN, 7 MAX (signed).
- sat_en  in  1  1 = saturate ADD/SUB/MUL; 0 = wrap.
- busy  out  1  high from the start edge until done.
- done  out  1  one-cycle pulse; S, S_len and R are valid.
- S  out  BITS x MAX_LEN  result vector.
- S_len  out  LEN_W  result length.
- R  out  RW  signed sum of S[0..S_len-1].

Behaviour:
- Reset (async assert, sync release): FSM enters IDLE; busy, done, S_len, R and every S[i] are driven to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE with start=1 at edge E0:
  - Latch A, B, scalar, op_sel, scalar_sel and sat_en into internal registers; later input changes have no effect.
  - Compute len = scalar_sel ? A_len : min(A_len, B_len), then clamp to MAX_LEN.
  - Clear S and R, set S_len = len, set busy = 1, clear the beat index.
  - Go to RUN, or to DONE if len = 0.
- RUN, each edge:
  - Lane j handles element idx = base + j; S[idx] = op(A[idx], B or scalar).
  - If idx >= len, S[idx] is written as 0.
  - R accumulates the sign-extended results of lanes with idx < len.
  - base advances by LANES.
  - After the beat with base + LANES >= len, go to DONE.
  - Beat count = ceil(len / LANES).
- DONE: done = 1 and busy = 1 for exactly one cycle, then IDLE with busy = 0.
- Latency: for len > 0, done is high during the cycle after edge E(ceil(len/LANES) + 1). For len = 0, done is high after edge E1.
- S, S_len and R hold their values after done until the next accepted start.
- start while busy is ignored and is not queued. start held high in IDLE after done begins a new operation.
- Arithmetic:
  - Compute in BITS+1 bits for ADD/SUB and 2*BITS bits for MUL.
  - MUL result is the product shifted arithmetically right by MULT_SHIFT.
  - sat_en=1 clamps to [-2^(BITS-1), 2^(BITS-1)-1]; otherwise the low BITS bits are kept.
  - Logic ops and MIN/MAX are never affected by sat_en.
- R never overflows for a sum of at most MAX_LEN results.
- Reset mid-RUN: the operation is abandoned, no done pulse is produced, and all outputs return to reset values.

Decomposition:
- Package vec_alu_pkg:
  - op_t enum (OP_ADD..OP_MAX).
  - state_t enum (IDLE, RUN, DONE).
  - sat function sat_to_bits(value, width).
- Sub-module vector_lane_op: combinational single-element op with saturation, instantiated LANES times via generate.
- Top level holds the FSM, operand latches, beat index, S registers and the reduction accumulator.

Test Plan (BITS=8, LANES=4, MAX_LEN=8):
1. ADD, A=[0,5,10,20], B=[1,1,1,1], both lengths 4, start at E0 -> S=[1,6,11,21,0,0,0,0], S_len=4, R=39, done during cycle after E2, busy low after.
2. SUB, scalar_sel=1, scalar=1, A[0]=-128, A_len=1 -> sat_en=1 gives S[0]=-128; sat_en=0 gives S[0]=127.
3. MUL, A[0]=16, B[0]=16, len 1 -> sat_en=1 gives 127; sat_en=0 gives 0. Rebuild with MULT_SHIFT=4: 16 regardless of sat_en.
4. Length handling:
   - A_len=6, B_len=6, ADD with B=0 -> two RUN beats, done after E3, S[6]=S[7]=0, S_len=6.
   - A_len=5, B_len=3 -> S_len=3.
   - scalar_sel=1, A_len=20 -> S_len=8.
5. A_len=0 -> done after E1, S all 0, R=0.
6. Handshake and reset:
   - Pulse start during RUN -> ignored; exactly one done.
   - Drop rst_n mid-RUN -> busy, S and R go to 0 immediately; no done pulse.
   - After rst_n releases, a new start completes normally.

Source files
------------

// File: rtl/vec_alu_pkg.sv
// Shared types and the saturation helper for the vector stream ALU.
package vec_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_MIN = 3'd6,
    OP_MAX = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Clamp a signed value to the range of a signed 'width'-bit number.
  function automatic logic signed [31:0] sat_to_bits(input logic signed [31:0] value,
                                                     input int unsigned width);
    logic signed [31:0] max_v;
    logic signed [31:0] min_v;
    max_v = (32'sd1 <<< (width - 1)) - 32'sd1;
    min_v = -(32'sd1 <<< (width - 1));
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end
    return value;
  endfunction

endpackage

// File: rtl/vector_stream_alu_if.sv
// Operand/result bundle between the requester and the vector stream ALU.
interface vector_stream_alu_if #(
  parameter int unsigned BITS    = 8,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned RW      = BITS + $clog2(MAX_LEN)
);
  logic                    start;
  logic signed [BITS-1:0]  A [MAX_LEN];
  logic [LEN_W-1:0]        A_len;
  logic signed [BITS-1:0]  B [MAX_LEN];
  logic [LEN_W-1:0]        B_len;
  logic signed [BITS-1:0]  scalar;
  logic                    scalar_sel;
  logic [2:0]              op_sel;
  logic                    sat_en;
  logic                    busy;
  logic                    done;
  logic signed [BITS-1:0]  S [MAX_LEN];
  logic [LEN_W-1:0]        S_len;
  logic signed [RW-1:0]    R;

  modport master (
    output start, A, A_len, B, B_len, scalar, scalar_sel, op_sel, sat_en,
    input  busy, done, S, S_len, R
  );

  modport slave (
    input  start, A, A_len, B, B_len, scalar, scalar_sel, op_sel, sat_en,
    output busy, done, S, S_len, R
  );
endinterface

// File: rtl/vector_lane_op.sv
// Combinational single-element ALU with optional signed saturation.
// Assumes BITS <= 16 so every intermediate fits in 32 bits.
module vector_lane_op
  import vec_alu_pkg::*;
#(
  parameter int unsigned BITS       = 8,
  parameter int unsigned MULT_SHIFT = 0
) (
  input  logic signed [BITS-1:0] a,
  input  logic signed [BITS-1:0] b,
  input  op_t                    op,
  input  logic                   sat_en,
  output logic signed [BITS-1:0] res
);

  logic signed [BITS:0]     sum;
  logic signed [BITS:0]     diff;
  logic signed [2*BITS-1:0] prod;
  logic signed [2*BITS-1:0] prod_sh;
  logic signed [31:0]       wide;

  // Full-precision arithmetic, then wrap or clamp back to BITS.
  always_comb begin
    sum     = {a[BITS-1], a} + {b[BITS-1], b};
    diff    = {a[BITS-1], a} - {b[BITS-1], b};
    prod    = (2*BITS)'(a) * (2*BITS)'(b);
    prod_sh = prod >>> MULT_SHIFT;
    wide    = '0;
    res     = '0;
    case (op)
      OP_ADD:  wide = 32'(sum);
      OP_SUB:  wide = 32'(diff);
      OP_MUL:  wide = 32'(prod_sh);
      default: wide = '0;
    endcase
    case (op)
      OP_ADD, OP_SUB, OP_MUL: res = sat_en ? BITS'(sat_to_bits(wide, BITS)) : BITS'(wide);
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_MIN:  res = (a < b) ? a : b;
      OP_MAX:  res = (a > b) ? a : b;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/vector_stream_alu.sv
// Lane-parallel vector ALU: latches operands on start, processes LANES
// elements per RUN beat, accumulates a running sum, pulses done once.
module vector_stream_alu
  import vec_alu_pkg::*;
#(
  parameter int unsigned BITS       = 8,
  parameter int unsigned LANES      = 4,
  parameter int unsigned MAX_LEN    = 16,
  parameter int unsigned MULT_SHIFT = 0,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned RW         = BITS + $clog2(MAX_LEN)
) (
  input logic clk,
  input logic rst_n,
  vector_stream_alu_if.slave bus
);

  localparam int unsigned IW = LEN_W + 1;
  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] MaxLenW = LEN_W'(MAX_LEN);

  state_t                 state_q, state_d;
  logic signed [BITS-1:0] a_q [MAX_LEN];
  logic signed [BITS-1:0] a_d [MAX_LEN];
  logic signed [BITS-1:0] b_q [MAX_LEN];
  logic signed [BITS-1:0] b_d [MAX_LEN];
  logic signed [BITS-1:0] s_q [MAX_LEN];
  logic signed [BITS-1:0] s_d [MAX_LEN];
  logic signed [BITS-1:0] scalar_q, scalar_d;
  op_t                    op_q, op_d;
  logic                   scalar_sel_q, scalar_sel_d;
  logic                   sat_q, sat_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [LEN_W-1:0]       s_len_q, s_len_d;
  logic [IW-1:0]          base_q, base_d;
  logic signed [RW-1:0]   r_q, r_d;
  logic signed [RW-1:0]   acc;

  logic [LEN_W-1:0]       req_len;
  logic [LEN_W-1:0]       eff_len;

  logic [IW-1:0]          lane_idx   [LANES];
  logic                   lane_valid [LANES];
  logic signed [BITS-1:0] lane_a     [LANES];
  logic signed [BITS-1:0] lane_b     [LANES];
  logic signed [BITS-1:0] lane_res   [LANES];

  // Requested length: shorter operand (or A alone with scalar), capped at MAX_LEN.
  always_comb begin
    req_len = bus.scalar_sel ? bus.A_len : ((bus.A_len < bus.B_len) ? bus.A_len : bus.B_len);
    eff_len = (req_len > MaxLenW) ? MaxLenW : req_len;
  end

  // Route the current beat's elements to the lanes.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      lane_idx[j]   = base_q + IW'(j);
      lane_valid[j] = lane_idx[j] < {1'b0, len_q};
      lane_a[j]     = '0;
      lane_b[j]     = scalar_sel_q ? scalar_q : '0;
      if (lane_idx[j] < IW'(MAX_LEN)) begin
        lane_a[j] = a_q[lane_idx[j][AW-1:0]];
        if (!scalar_sel_q) lane_b[j] = b_q[lane_idx[j][AW-1:0]];
      end
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    vector_lane_op #(
      .BITS      (BITS),
      .MULT_SHIFT(MULT_SHIFT)
    ) u_lane (
      .a     (lane_a[j]),
      .b     (lane_b[j]),
      .op    (op_q),
      .sat_en(sat_q),
      .res   (lane_res[j])
    );
  end

  // FSM next state plus operand latch, result write and reduction updates.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    s_d          = s_q;
    scalar_d     = scalar_q;
    op_d         = op_q;
    scalar_sel_d = scalar_sel_q;
    sat_d        = sat_q;
    len_d        = len_q;
    s_len_d      = s_len_q;
    base_d       = base_q;
    r_d          = r_q;
    acc          = r_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d          = bus.A;
          b_d          = bus.B;
          scalar_d     = bus.scalar;
          op_d         = op_t'(bus.op_sel);
          scalar_sel_d = bus.scalar_sel;
          sat_d        = bus.sat_en;
          len_d        = eff_len;
          s_len_d      = eff_len;
          base_d       = '0;
          r_d          = '0;
          for (int i = 0; i < MAX_LEN; i++) s_d[i] = '0;
          state_d      = (eff_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        for (int j = 0; j < LANES; j++) begin
          if (lane_idx[j] < IW'(MAX_LEN)) begin
            s_d[lane_idx[j][AW-1:0]] = lane_valid[j] ? lane_res[j] : '0;
          end
          if (lane_valid[j]) acc = acc + RW'(lane_res[j]);
        end
        r_d    = acc;
        base_d = base_q + IW'(LANES);
        if (base_q + IW'(LANES) >= {1'b0, len_q}) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears every visible output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      for (int i = 0; i < MAX_LEN; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        s_q[i] <= '0;
      end
      scalar_q     <= '0;
      op_q         <= OP_ADD;
      scalar_sel_q <= 1'b0;
      sat_q        <= 1'b0;
      len_q        <= '0;
      s_len_q      <= '0;
      base_q       <= '0;
      r_q          <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      s_q          <= s_d;
      scalar_q     <= scalar_d;
      op_q         <= op_d;
      scalar_sel_q <= scalar_sel_d;
      sat_q        <= sat_d;
      len_q        <= len_d;
      s_len_q      <= s_len_d;
      base_q       <= base_d;
      r_q          <= r_d;
    end
  end

  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = (state_q == DONE);
  assign bus.S     = s_q;
  assign bus.S_len = s_len_q;
  assign bus.R     = r_q;

endmodule

// File: tb/tb_vector_stream_alu.sv
// Directed bench for vector_stream_alu (BITS=8, LANES=4, MAX_LEN=8).
module tb_vector_stream_alu;
  localparam int unsigned BITS    = 8;
  localparam int unsigned LANES   = 4;
  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned RW      = 11;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  vector_stream_alu_if #(.BITS(BITS), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .RW(RW)) bus ();
  vector_stream_alu_if #(.BITS(BITS), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .RW(RW)) bus4 ();

  vector_stream_alu #(
    .BITS(BITS), .LANES(LANES), .MAX_LEN(MAX_LEN), .MULT_SHIFT(0), .LEN_W(LEN_W), .RW(RW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  vector_stream_alu #(
    .BITS(BITS), .LANES(LANES), .MAX_LEN(MAX_LEN), .MULT_SHIFT(4), .LEN_W(LEN_W), .RW(RW)
  ) dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Raise start after edge E0, drop it after E1, return edges until done is seen.
  task automatic run_start(input bit use4, output int edges);
    edges = 0;
    @(posedge clk); #1;
    if (use4) bus4.start = 1'b1; else bus.start = 1'b1;
    @(posedge clk); #1;
    edges = 1;
    bus.start  = 1'b0;
    bus4.start = 1'b0;
    while (!(use4 ? bus4.done : bus.done) && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic set_inputs(input int op, input bit ssel, input bit sat,
                            input int alen, input int blen);
    bus.op_sel     = 3'(op);
    bus.scalar_sel = ssel;
    bus.sat_en     = sat;
    bus.A_len      = 8'(alen);
    bus.B_len      = 8'(blen);
  endtask

  task automatic test_reset();
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_busy_done: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    tests_run++;
    if (bus.S_len !== 8'd0 || bus.R !== 11'sd0) begin
      tests_failed++;
      $display("FAIL reset_len_r: got S_len=%0d R=%0d expected 0 0", bus.S_len, bus.R);
    end
    for (int i = 0; i < MAX_LEN; i++) begin
      tests_run++;
      if (bus.S[i] !== 8'sd0) begin
        tests_failed++;
        $display("FAIL reset_S[%0d]: got %0d expected 0", i, bus.S[i]);
      end
    end
  endtask

  task automatic test_add();
    int edges;
    logic signed [7:0] exp_s [8];
    exp_s = '{8'sd1, 8'sd6, 8'sd11, 8'sd21, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
    bus.A = '{8'sd0, 8'sd5, 8'sd10, 8'sd20, 8'sd9, 8'sd9, 8'sd9, 8'sd9};
    bus.B = '{8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1};
    set_inputs(0, 1'b0, 1'b0, 4, 4);
    run_start(1'b0, edges);
    tests_run++;
    if (edges !== 2) begin
      tests_failed++;
      $display("FAIL add_latency: got done after edge %0d expected 2", edges);
    end
    tests_run++;
    if (bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL add_busy_at_done: got %b expected 1", bus.busy);
    end
    for (int i = 0; i < MAX_LEN; i++) begin
      tests_run++;
      if (bus.S[i] !== exp_s[i]) begin
        tests_failed++;
        $display("FAIL add_S[%0d]: got %0d expected %0d", i, bus.S[i], exp_s[i]);
      end
    end
    tests_run++;
    if (bus.S_len !== 8'd4 || bus.R !== 11'sd39) begin
      tests_failed++;
      $display("FAIL add_len_r: got S_len=%0d R=%0d expected 4 39", bus.S_len, bus.R);
    end
    @(posedge clk); #1;
    tests_run++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_after_done: got done=%b busy=%b expected 0 0", bus.done, bus.busy);
    end
    bus.A = '{8'sd99, 8'sd99, 8'sd99, 8'sd99, 8'sd99, 8'sd99, 8'sd99, 8'sd99};
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (bus.S[1] !== 8'sd6 || bus.R !== 11'sd39) begin
      tests_failed++;
      $display("FAIL add_hold: got S[1]=%0d R=%0d expected 6 39", bus.S[1], bus.R);
    end
  endtask

  task automatic test_sub_sat();
    int edges;
    bus.A[0]   = -8'sd128;
    bus.scalar = 8'sd1;
    for (int k = 0; k < 2; k++) begin
      set_inputs(1, 1'b1, (k == 0), 1, 0);
      run_start(1'b0, edges);
      tests_run++;
      if (k == 0 && (bus.S[0] !== -8'sd128 || bus.R !== -11'sd128)) begin
        tests_failed++;
        $display("FAIL sub_sat: got S0=%0d R=%0d expected -128 -128", bus.S[0], bus.R);
      end else if (k == 1 && (bus.S[0] !== 8'sd127 || bus.R !== 11'sd127)) begin
        tests_failed++;
        $display("FAIL sub_wrap: got S0=%0d R=%0d expected 127 127", bus.S[0], bus.R);
      end
    end
  endtask

  task automatic test_mul();
    int edges;
    bus.A[0]  = 8'sd16;
    bus.B[0]  = 8'sd16;
    bus4.A    = bus.A;
    bus4.B    = bus.B;
    bus4.A[0] = 8'sd16;
    bus4.B[0] = 8'sd16;
    for (int k = 0; k < 2; k++) begin
      set_inputs(2, 1'b0, (k == 0), 1, 1);
      bus4.op_sel = 3'd2; bus4.scalar_sel = 1'b0; bus4.sat_en = (k == 0);
      bus4.A_len  = 8'd1; bus4.B_len = 8'd1;
      run_start(1'b0, edges);
      tests_run++;
      if (bus.S[0] !== ((k == 0) ? 8'sd127 : 8'sd0)) begin
        tests_failed++;
        $display("FAIL mul_sat%0d: got %0d expected %0d", k, bus.S[0], (k == 0) ? 127 : 0);
      end
      run_start(1'b1, edges);
      tests_run++;
      if (bus4.S[0] !== 8'sd16 || edges !== 2) begin
        tests_failed++;
        $display("FAIL mul_shift4_%0d: got %0d edges %0d expected 16 edges 2",
                 k, bus4.S[0], edges);
      end
    end
  endtask

  task automatic test_lengths();
    int edges;
    for (int i = 0; i < MAX_LEN; i++) begin
      bus.A[i] = 8'(i + 1);
      bus.B[i] = 8'sd0;
    end
    set_inputs(0, 1'b0, 1'b0, 6, 6);
    run_start(1'b0, edges);
    tests_run++;
    if (edges !== 3 || bus.S_len !== 8'd6 || bus.R !== 11'sd21) begin
      tests_failed++;
      $display("FAIL len6: got edges=%0d S_len=%0d R=%0d expected 3 6 21",
               edges, bus.S_len, bus.R);
    end
    tests_run++;
    if (bus.S[5] !== 8'sd6 || bus.S[6] !== 8'sd0 || bus.S[7] !== 8'sd0) begin
      tests_failed++;
      $display("FAIL len6_tail: got S5=%0d S6=%0d S7=%0d expected 6 0 0",
               bus.S[5], bus.S[6], bus.S[7]);
    end
    set_inputs(0, 1'b0, 1'b0, 5, 3);
    run_start(1'b0, edges);
    tests_run++;
    if (edges !== 2 || bus.S_len !== 8'd3 || bus.S[3] !== 8'sd0 || bus.R !== 11'sd6) begin
      tests_failed++;
      $display("FAIL len_min: got edges=%0d S_len=%0d S3=%0d R=%0d expected 2 3 0 6",
               edges, bus.S_len, bus.S[3], bus.R);
    end
    bus.scalar = 8'sd0;
    set_inputs(0, 1'b1, 1'b0, 20, 0);
    run_start(1'b0, edges);
    tests_run++;
    if (edges !== 3 || bus.S_len !== 8'd8 || bus.S[7] !== 8'sd8 || bus.R !== 11'sd36) begin
      tests_failed++;
      $display("FAIL len_clamp: got edges=%0d S_len=%0d S7=%0d R=%0d expected 3 8 8 36",
               edges, bus.S_len, bus.S[7], bus.R);
    end
  endtask

  task automatic test_zero_len();
    int edges;
    set_inputs(0, 1'b0, 1'b0, 0, 5);
    run_start(1'b0, edges);
    tests_run++;
    if (edges !== 1 || bus.S_len !== 8'd0 || bus.R !== 11'sd0) begin
      tests_failed++;
      $display("FAIL zero_len: got edges=%0d S_len=%0d R=%0d expected 1 0 0",
               edges, bus.S_len, bus.R);
    end
    for (int i = 0; i < MAX_LEN; i++) begin
      tests_run++;
      if (bus.S[i] !== 8'sd0) begin
        tests_failed++;
        $display("FAIL zero_len_S[%0d]: got %0d expected 0", i, bus.S[i]);
      end
    end
  endtask

  task automatic test_logic();
    int edges;
    bus.A = '{-8'sd5, 8'sd3, 8'sd0, 8'sd7, 8'sd1, 8'sd1, 8'sd1, 8'sd1};
    bus.B = '{8'sd2, -8'sd4, 8'sd0, 8'sd7, 8'sd1, 8'sd1, 8'sd1, 8'sd1};
    set_inputs(7, 1'b0, 1'b1, 4, 4);
    run_start(1'b0, edges);
    tests_run++;
    if (bus.S[0] !== 8'sd2 || bus.S[1] !== 8'sd3 || bus.R !== 11'sd12) begin
      tests_failed++;
      $display("FAIL max: got S0=%0d S1=%0d R=%0d expected 2 3 12", bus.S[0], bus.S[1], bus.R);
    end
    set_inputs(5, 1'b0, 1'b1, 4, 4);
    run_start(1'b0, edges);
    tests_run++;
    if (bus.S[0] !== -8'sd7 || bus.S[1] !== -8'sd1 || bus.R !== -11'sd8) begin
      tests_failed++;
      $display("FAIL xor: got S0=%0d S1=%0d R=%0d expected -7 -1 -8", bus.S[0], bus.S[1], bus.R);
    end
    bus.B = '{-8'sd1, 8'sd2, -8'sd3, 8'sd4, 8'sd1, 8'sd1, 8'sd1, 8'sd1};
    bus.A = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd1, 8'sd1, 8'sd1, 8'sd1};
    set_inputs(2, 1'b0, 1'b0, 4, 4);
    run_start(1'b0, edges);
    tests_run++;
    if (bus.S[0] !== -8'sd1 || bus.S[2] !== -8'sd9 || bus.R !== 11'sd10) begin
      tests_failed++;
      $display("FAIL mul_mix: got S0=%0d S2=%0d R=%0d expected -1 -9 10", bus.S[0], bus.S[2], bus.R);
    end
  endtask

  task automatic test_start_ignored();
    int dones;
    dones = 0;
    for (int i = 0; i < MAX_LEN; i++) begin
      bus.A[i] = 8'(i + 1);
      bus.B[i] = 8'sd0;
    end
    set_inputs(0, 1'b0, 1'b0, 8, 8);
    @(posedge clk); #1; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) bus.A[i] = 8'sd100;
    if (bus.done === 1'b1) dones++;
    @(posedge clk); #1; bus.start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus.done === 1'b1) dones++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (dones !== 1) begin
      tests_failed++;
      $display("FAIL busy_start_dones: got %0d done pulses expected 1", dones);
    end
    tests_run++;
    if (bus.S[0] !== 8'sd1 || bus.S[7] !== 8'sd8 || bus.R !== 11'sd36) begin
      tests_failed++;
      $display("FAIL busy_start_latch: got S0=%0d S7=%0d R=%0d expected 1 8 36",
               bus.S[0], bus.S[7], bus.R);
    end
  endtask

  task automatic test_reset_mid_run();
    int dones;
    dones = 0;
    for (int i = 0; i < MAX_LEN; i++) bus.A[i] = 8'(i + 1);
    set_inputs(0, 1'b0, 1'b0, 8, 8);
    @(posedge clk); #1; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (bus.busy !== 1'b1 || bus.S[0] !== 8'sd1) begin
      tests_failed++;
      $display("FAIL mid_run_pre: got busy=%b S0=%0d expected 1 1", bus.busy, bus.S[0]);
    end
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.R !== 11'sd0 || bus.S[0] !== 8'sd0 || bus.S_len !== 8'd0) begin
      tests_failed++;
      $display("FAIL mid_run_reset: got busy=%b R=%0d S0=%0d S_len=%0d expected 0 0 0 0",
               bus.busy, bus.R, bus.S[0], bus.S_len);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dones++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dones++;
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("FAIL mid_run_no_done: got %0d done pulses expected 0", dones);
    end
  endtask

  task automatic test_after_reset();
    int edges;
    for (int i = 0; i < MAX_LEN; i++) begin
      bus.A[i] = 8'(i + 1);
      bus.B[i] = 8'sd2;
    end
    set_inputs(0, 1'b0, 1'b0, 8, 8);
    run_start(1'b0, edges);
    tests_run++;
    if (edges !== 3 || bus.S[7] !== 8'sd10 || bus.R !== 11'sd52) begin
      tests_failed++;
      $display("FAIL after_reset: got edges=%0d S7=%0d R=%0d expected 3 10 52",
               edges, bus.S[7], bus.R);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus4.start   = 1'b0;
    bus.scalar   = 8'sd0;
    bus4.scalar  = 8'sd0;
    for (int i = 0; i < MAX_LEN; i++) begin
      bus.A[i]  = 8'sd0;
      bus.B[i]  = 8'sd0;
      bus4.A[i] = 8'sd0;
      bus4.B[i] = 8'sd0;
    end
    set_inputs(0, 1'b0, 1'b0, 0, 0);
    bus4.op_sel = 3'd0; bus4.scalar_sel = 1'b0; bus4.sat_en = 1'b0;
    bus4.A_len  = 8'd0; bus4.B_len = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_add();
    test_sub_sat();
    test_mul();
    test_lengths();
    test_zero_len();
    test_logic();
    test_start_ignored();
    test_reset_mid_run();
    test_after_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
